// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequencer for the LED-pattern ROM. Walks the ROM address
// through a programmable window (up or down), one step per prescaler period
// in RUN or one step per step pulse in PAUSE, and registers the ROM output
// onto the LEDs. A decouple hold parks everything while the partition is
// reconfigured and re-primes the ROM pipeline on release.
//
// Optional build macro: LED_SEQ_PWM_EN adds a duty[3:0] input and a 4-bit
// PWM counter that dims the registered LED value.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | stopped, ROM disabled, LEDs dark
// ST_PRIME  | ROM enabled for 2 cycles to fill the read pipeline
// ST_RUN    | free-running, advance on prescaler terminal count
// ST_PAUSE  | frozen prescaler, advance only on step
// ST_DECOUP | partition under reconfiguration, everything held
module led_seq_ctrl #(
  parameter int PRESCALE = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        dir,
  input  logic [11:0] addr_lo,
  input  logic [11:0] addr_hi,
  input  logic        decouple,
  input  logic [3:0]  rom_data,
`ifdef LED_SEQ_PWM_EN
  input  logic [3:0]  duty,
`endif
  output logic        rom_en,
  output logic [11:0] rom_addr,
  output logic [3:0]  led,
  output logic        tick,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_PAUSE,
    ST_DECOUP
  } state_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(PRESCALE - 1);

  state_t            state_q, state_d;
  logic              saved_pause_q, saved_pause_d;  // 1: return to PAUSE, 0: RUN
  logic              prime_q, prime_d;              // second PRIME cycle
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [11:0]       addr_q, addr_d;
  logic [3:0]        led_q, led_d;
  logic              tick_q, tick_d;
  logic              advance;
  logic              win_bad;
  logic [11:0]       next_addr;
  logic [11:0]       load_addr;

  // An inverted window pins the address to addr_lo.
  assign win_bad   = addr_lo > addr_hi;
  assign load_addr = (win_bad || !dir) ? addr_lo : addr_hi;

  // Next address for one advance, wrapping inside the window and snapping
  // back to the entry bound when the current address lies outside it.
  always_comb begin
    next_addr = addr_q;
    if (win_bad) begin
      next_addr = addr_lo;
    end else if (!dir) begin
      if (addr_q < addr_lo || addr_q >= addr_hi) next_addr = addr_lo;
      else                                        next_addr = addr_q + 12'd1;
    end else begin
      if (addr_q > addr_hi || addr_q <= addr_lo) next_addr = addr_hi;
      else                                        next_addr = addr_q - 12'd1;
    end
  end

  // Next-state, prescaler, address and LED capture; decouple outranks
  // stop, which outranks start, step and the prescaler.
  always_comb begin
    state_d       = state_q;
    saved_pause_d = saved_pause_q;
    prime_d       = 1'b0;
    presc_d       = presc_q;
    led_d         = led_q;
    advance       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        led_d = 4'd0;
        if (start) begin
          state_d       = ST_PRIME;
          saved_pause_d = 1'b0;
        end
      end
      ST_PRIME: begin
        if (decouple) begin
          state_d = ST_DECOUP;
        end else if (prime_q) begin
          state_d = saved_pause_q ? ST_PAUSE : ST_RUN;
          presc_d = '0;
        end else begin
          prime_d = 1'b1;
        end
      end
      ST_RUN: begin
        led_d = rom_data;
        if (decouple) begin
          state_d = ST_DECOUP;
        end else if (stop) begin
          state_d       = ST_PAUSE;
          saved_pause_d = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
          advance = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        led_d = rom_data;
        if (decouple) begin
          state_d = ST_DECOUP;
        end else if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d       = ST_RUN;
          saved_pause_d = 1'b0;
          presc_d       = '0;
        end else if (step) begin
          advance = 1'b1;
        end
      end
      ST_DECOUP: begin
        if (!decouple) state_d = ST_PRIME;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address register input: load on start from IDLE, step on advance.
  always_comb begin
    addr_d = addr_q;
    tick_d = advance;
    if (state_q == ST_IDLE && start) addr_d = load_addr;
    else if (advance)                addr_d = next_addr;
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      saved_pause_q <= 1'b0;
      prime_q       <= 1'b0;
      presc_q       <= '0;
      addr_q        <= 12'd0;
      led_q         <= 4'd0;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_pause_q <= saved_pause_d;
      prime_q       <= prime_d;
      presc_q       <= presc_d;
      addr_q        <= addr_d;
      led_q         <= led_d;
      tick_q        <= tick_d;
    end
  end

  assign rom_en   = (state_q == ST_PRIME) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign rom_addr = addr_q;
  assign tick     = tick_q;
  assign busy     = state_q != ST_IDLE;

`ifdef LED_SEQ_PWM_EN
  logic [3:0] pwm_q, pwm_d;

  // PWM counter runs only while the pattern is live; DECOUP freezes it.
  always_comb begin
    pwm_d = pwm_q;
    if (state_q == ST_RUN || state_q == ST_PAUSE) pwm_d = pwm_q + 4'd1;
  end

  // PWM counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_q <= 4'd0;
    else     pwm_q <= pwm_d;
  end

  assign led = led_q & {4{pwm_q < duty}};
`else
  assign led = led_q;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with PRESCALE=4 and a 1-cycle ROM whose word at
// address a is 1<<(a%4). Stimulus queues the expected rom_addr, led and
// cycle gap for every tick; a negedge monitor pops on each tick.
module tb_led_seq_ctrl;
  localparam int PRESCALE = 4;
  localparam int CNT_W    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b0, decouple = 1'b0;
  logic [11:0] addr_lo = 12'd0, addr_hi = 12'd0;
  logic [3:0]  rom_data;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [3:0]  led;
  logic        tick, busy;
`ifdef LED_SEQ_PWM_EN
  logic [3:0]  duty = 4'd15;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int mark  = 0;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  led;
    int          gap;   // cycles since previous tick or stimulus edge; -1 = any
  } exp_t;
  exp_t exp_q[$];

  led_seq_ctrl #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .dir      (dir),
    .addr_lo  (addr_lo),
    .addr_hi  (addr_hi),
    .decouple (decouple),
    .rom_data (rom_data),
`ifdef LED_SEQ_PWM_EN
    .duty     (duty),
`endif
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .led      (led),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: registered read, zero when disabled.
  always @(posedge clk or posedge rst) begin
    if (rst)         rom_data <= 4'd0;
    else if (rom_en) rom_data <= 4'b0001 << rom_addr[1:0];
    else             rom_data <= 4'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // With PWM built in, the LEDs may be dimmed, so only extra bits are errors.
  task automatic check_led(input string name, input logic [3:0] act, input logic [3:0] req);
`ifdef LED_SEQ_PWM_EN
    n_vec++;
    if ((act & ~req) !== 4'd0) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected subset of 0x%0h", name, act, req);
    end
`else
    check(name, {28'd0, act}, {28'd0, req});
`endif
  endtask

  task automatic push(input logic [11:0] a, input logic [3:0] l, input int g);
    exp_t e;
    e.addr = a;
    e.led  = l;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  // One-cycle pulse on any combination of start/stop/step; mark = sampling edge.
  task automatic pulse(input logic do_start, input logic do_stop, input logic do_step);
    @(posedge clk);
    #1;
    start = do_start;
    stop  = do_stop;
    step  = do_step;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
    mark  = cyc;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every tick must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && tick) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_tick: rom_addr=0x%0h, none expected", rom_addr);
      end else begin
        e = exp_q.pop_front();
        check("tick_addr", rom_addr, e.addr);
        check_led("tick_led", led, e.led);
        if (e.gap >= 0) check("tick_gap", cyc - mark, e.gap);
      end
      mark = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d ticks pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_led", led, 0);
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // up-count wrap, window 0..7
    addr_lo = 12'd0; addr_hi = 12'd7; dir = 1'b0;
    push(12'd1, 4'h1, 6); push(12'd2, 4'h2, 4); push(12'd3, 4'h4, 4);
    push(12'd4, 4'h8, 4); push(12'd5, 4'h1, 4); push(12'd6, 4'h2, 4);
    push(12'd7, 4'h4, 4); push(12'd0, 4'h8, 4); push(12'd1, 4'h1, 4);
    pulse(1'b1, 1'b0, 1'b0);
    check("prime_busy", busy, 1);
    check("prime_rom_en", rom_en, 1);
    check("prime_led", led, 0);
    wait_drain(60, "up_drain");
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("up_stop_busy", busy, 0);
    check("up_stop_rom_en", rom_en, 0);
    check("up_stop_led", led, 0);
    check("up_stop_addr", rom_addr, 1);

    // down-count window 2..5
    dir = 1'b1; addr_lo = 12'd2; addr_hi = 12'd5;
    push(12'd4, 4'h2, 6); push(12'd3, 4'h1, 4); push(12'd2, 4'h8, 4);
    push(12'd5, 4'h4, 4); push(12'd4, 4'h2, 4);
    pulse(1'b1, 1'b0, 1'b0);
    check("down_load", rom_addr, 5);
    wait_drain(40, "down_drain");

    // pause, then three steps going up
    pulse(1'b0, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("pause_addr", rom_addr, 4);
    check_led("pause_led", led, 4'h1);
    check("pause_busy", busy, 1);
    check("pause_rom_en", rom_en, 1);
    dir = 1'b0;
    push(12'd5, 4'h1, 0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    push(12'd2, 4'h2, 0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    push(12'd3, 4'h4, 0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    wait_drain(10, "step_drain");
    pulse(1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("stopstep_busy", busy, 0);
    check("stopstep_addr", rom_addr, 3);
    check("stopstep_led", led, 0);
    check("stopstep_rom_en", rom_en, 0);

    // decouple hold in RUN
    addr_lo = 12'd0; addr_hi = 12'd7; dir = 1'b0;
    push(12'd1, 4'h1, 6); push(12'd2, 4'h2, 4);
    pulse(1'b1, 1'b0, 1'b0);
    check("restart_load", rom_addr, 0);
    wait_drain(30, "pre_decouple_drain");
    repeat (2) @(posedge clk);
    #1;
    decouple = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("decoup_rom_en", rom_en, 0);
    check("decoup_addr", rom_addr, 2);
    check_led("decoup_led", led, 4'h4);
    check("decoup_busy", busy, 1);
    push(12'd3, 4'h4, 6); push(12'd4, 4'h8, 4);
    @(posedge clk);
    #1;
    decouple = 1'b0;
    @(posedge clk);
    #1;
    mark = cyc;
    check("reprime_rom_en", rom_en, 1);
    check("reprime_addr", rom_addr, 2);
    wait_drain(30, "post_decouple_drain");

    // asynchronous reset mid-run
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_addr", rom_addr, 0);
    check("arst_led", led, 0);
    check("arst_busy", busy, 0);
    check("arst_rom_en", rom_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    addr_lo = 12'd3; addr_hi = 12'd6;
    push(12'd4, 4'h8, 6); push(12'd5, 4'h1, 4);
    pulse(1'b1, 1'b0, 1'b0);
    check("arst_restart_load", rom_addr, 3);
    wait_drain(30, "arst_drain");

    // inverted window pins to addr_lo; out-of-window snaps to the bound
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    addr_lo = 12'd9; addr_hi = 12'd4; dir = 1'b1;
    push(12'd9, 4'h2, 6);
    pulse(1'b1, 1'b0, 1'b0);
    check("inv_load", rom_addr, 9);
    wait_drain(20, "inv_drain");
    addr_lo = 12'd2; addr_hi = 12'd5;
    push(12'd5, 4'h2, 4);
    wait_drain(10, "outwin_down_drain");
    dir = 1'b0;
    push(12'd2, 4'h2, 4);
    wait_drain(10, "hi_wrap_drain");
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);

`ifdef LED_SEQ_PWM_EN
    begin
      int lit;
      addr_lo = 12'd0; addr_hi = 12'd7; dir = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      pulse(1'b0, 1'b1, 1'b0);
      duty = 4'd8;
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (led != 4'd0) lit++;
      end
      check("pwm_duty8", lit, 8);
      #1;
      duty = 4'd0;
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (led != 4'd0) lit++;
      end
      check("pwm_duty0", lit, 0);
      duty = 4'd15;
      pulse(1'b0, 1'b1, 1'b0);
    end
`endif

    repeat (4) @(posedge clk);
    #1;
    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Sequencer for the LED-pattern ROM inside the reconfigurable shift partition. It drives the ROM's enable and 12-bit address, advances the address once per prescaler period within a programmable window, and registers the 4-bit ROM output onto the LEDs. It also supports pause and single-step, and a decouple hold that is used while the partition is being reconfigured.

Parameters:
PRESCALE, 50000000, clocks per address advance in RUN; minimum 1.
CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= PRESCALE.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  1-cycle pulse: IDLE->run, or PAUSE->RUN
stop  in  1  1-cycle pulse: RUN->PAUSE, or PAUSE->IDLE
step  in  1  1-cycle pulse: single advance while in PAUSE
dir  in  1  0 = address up, 1 = address down; sampled at each advance
addr_lo  in  12  window low bound
addr_hi  in  12  window high bound
decouple  in  1  level; partition under reconfiguration
rom_data  in  4  ROM read data (1-cycle read latency)
rom_en  out  1  ROM enable; ROM output forces 0 when low
rom_addr  out  12  ROM address, registered
led  out  4  LED drive, registered
tick  out  1  1-cycle pulse, the cycle after each advance
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous): state=IDLE, rom_en=0, rom_addr=0, led=0, tick=0, busy=0, prescaler=0.
- States: IDLE, PRIME, RUN, PAUSE, DECOUP. A 1-bit saved state (RUN or PAUSE) records where to return after decouple.
- IDLE:
  - rom_en=0, led=0.
  - start -> PRIME with saved=RUN; rom_addr <= addr_lo if dir=0, else addr_hi.
- PRIME:
  - rom_en=1; lasts exactly 2 cycles to cover the ROM latency; led is held.
  - Then -> saved state, prescaler=0.
- RUN:
  - rom_en=1; led <= rom_data every cycle.
  - Prescaler counts 0..PRESCALE-1; on the terminal count, advance and reset the prescaler.
  - stop -> PAUSE, prescaler held.
- PAUSE:
  - rom_en=1; led <= rom_data every cycle; prescaler frozen.
  - step: one advance, stay in PAUSE.
  - start -> RUN, prescaler=0.
  - stop -> IDLE.
- Advance and window:
  - dir=0: next = (rom_addr >= addr_hi) ? addr_lo : rom_addr+1.
  - dir=1: next = (rom_addr <= addr_lo) ? addr_hi : rom_addr-1.
  - If rom_addr is outside [addr_lo, addr_hi], next = addr_lo (dir=0) or addr_hi (dir=1).
  - If addr_lo > addr_hi, rom_addr is forced to addr_lo.
  - tick is high in the cycle after rom_addr updates.
  - led reflects the new address 2 clock edges after rom_addr changes.
- DECOUP:
  - Entered from PRIME, RUN or PAUSE when decouple=1; saved keeps its current value (set to RUN/PAUSE when leaving those states).
  - rom_en=0. led, rom_addr and prescaler are held; rom_data is ignored; no ticks.
  - decouple=0 -> PRIME, then back to saved. rom_addr is unchanged.
  - decouple has no effect in IDLE.
- Priority within a cycle: rst > decouple > stop > start > step > prescaler advance.
- PAUSE with stop and step together: goes to IDLE, no advance.
- Address arithmetic is 12-bit and does not wrap outside the window logic.

Optional Feature:
LED_SEQ_PWM_EN
- Defined:
  - Adds input duty[3:0] and a free-running 4-bit pwm counter, active in RUN and PAUSE, reset 0.
  - led = led_reg & {4{pwm_cnt < duty}}.
  - duty=0 gives LEDs off; duty=15 gives 15/16 on.
  - DECOUP freezes the pwm counter.
- Undefined: no duty port; led = led_reg.

Test Plan:
- ROM model for all tests: rom[a] = 1<<(a%4), 1-cycle latency, output 0 when rom_en=0. Bench uses PRESCALE=4.
- Up-count wrap: start, lo=0, hi=7, dir=0 -> rom_addr 0,1..7,0 every 4 cycles; led 1,2,4,8,1; tick period 4; busy=1.
- Down-count window: dir=1, lo=2, hi=5 -> rom_addr 5,4,3,2,5; led 2,1,8,4,2.
- Pause and step: stop in RUN -> led frozen, no tick for 20 cycles. Three step pulses -> rom_addr +3 with 3 ticks. stop -> IDLE, led=0, rom_en=0, busy=0.
- Decouple: decouple=1 for 10 cycles in RUN -> rom_en=0, led and rom_addr held, no tick. Release -> 2-cycle PRIME, then RUN resumes from the same rom_addr.
- Reset mid-operation: rst asserted asynchronously mid-RUN -> all outputs 0 immediately; after release, start restarts from addr_lo.
- PWM (LED_SEQ_PWM_EN defined): duty=8 -> lit bit high 8 of every 16 cycles; duty=0 -> led=0 throughout.
